// File: rtl/aes_engine_arbiter.sv
// aes_engine_arbiter
// Shares one AES core between two requesters. Channel 0 carries the
// Diffie-Hellman key-exchange traffic, channel 1 carries user data. One block
// is in flight at a time: grant, issue to the core, wait for the result,
// hand it to the owner, then release the core with eng_o_stb.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   key_valid                  key loaded in the core; gates new grants only
//   req_valid[1:0]             per-channel request (bit n = channel n)
//   req_data0 / req_data1      128-bit block of each channel
//   req_ack[1:0]               one-cycle pulse: channel n's block accepted
//   resp_valid[1:0]            result held for channel n until resp_ready[n]
//   resp_data                  result block
//   resp_ready[1:0]            channel n consumes its result
//   eng_ready, eng_o_valid,
//   eng_dataout                core handshake inputs
//   eng_dat_stb, eng_datain,
//   eng_o_stb                  core handshake outputs
//   busy, grant                activity flag and channel owning the core
//   timeout_err                one-cycle pulse when the core never answers
//   done_cnt0 / done_cnt1      wrapping per-channel completion counters
module aes_engine_arbiter #(
  parameter int TIMEOUT      = 1024,  // WAIT_RESULT cycles before abort, >= 2
  parameter int CH0_PRIORITY = 0,     // 1: channel 0 always wins contention
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [1:0]       req_valid,
  input  logic [127:0]     req_data0,
  input  logic [127:0]     req_data1,
  output logic [1:0]       req_ack,
  output logic [1:0]       resp_valid,
  output logic [127:0]     resp_data,
  input  logic [1:0]       resp_ready,
  input  logic             eng_ready,
  output logic             eng_dat_stb,
  output logic [127:0]     eng_datain,
  input  logic             eng_o_valid,
  input  logic [127:0]     eng_dataout,
  output logic             eng_o_stb,
  output logic             busy,
  output logic             grant,
  output logic             timeout_err,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESULT,
    S_DELIVER,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         req_ack_q, req_ack_d;
  logic [1:0]         resp_valid_q, resp_valid_d;
  logic [127:0]       resp_data_q, resp_data_d;
  logic               eng_dat_stb_q, eng_dat_stb_d;
  logic [127:0]       eng_datain_q, eng_datain_d;
  logic               eng_o_stb_q, eng_o_stb_d;
  logic               timeout_err_q, timeout_err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   done_cnt0_q, done_cnt0_d;
  logic [CNT_W-1:0]   done_cnt1_q, done_cnt1_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pick;

  // Arbitration: a lone requester wins outright; under contention channel 0
  // wins in priority mode, otherwise whichever channel was not served last.
  always_comb begin
    pick = 1'b0;
    if (&req_valid) begin
      pick = (CH0_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick = req_valid[1];
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first; a path that skipped one would infer a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    req_ack_d     = 2'b00;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    eng_dat_stb_d = 1'b0;
    eng_datain_d  = eng_datain_q;
    eng_o_stb_d   = 1'b0;
    timeout_err_d = 1'b0;
    done_cnt0_d   = done_cnt0_q;
    done_cnt1_d   = done_cnt1_q;
    timer_d       = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (eng_ready && key_valid && (|req_valid)) begin
          // Strobe and ack are registered here so both are high during ISSUE.
          grant_d         = pick;
          eng_datain_d    = pick ? req_data1 : req_data0;
          eng_dat_stb_d   = 1'b1;
          req_ack_d[pick] = 1'b1;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        timer_d = timer_q + TMR_W'(1);
        // A result arriving on the last allowed cycle still counts.
        if (eng_o_valid) begin
          resp_data_d           = eng_dataout;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = S_DELIVER;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          eng_o_stb_d   = 1'b1;
          state_d       = S_RELEASE;
        end
      end
      S_DELIVER: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = 2'b00;
          eng_o_stb_d  = 1'b1;
          if (grant_q) done_cnt1_d = done_cnt1_q + CNT_W'(1);
          else         done_cnt0_d = done_cnt0_q + CNT_W'(1);
          state_d      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;  // channel 0 wins the first contention
      req_ack_q     <= 2'b00;
      resp_valid_q  <= 2'b00;
      resp_data_q   <= '0;
      eng_dat_stb_q <= 1'b0;
      eng_datain_q  <= '0;
      eng_o_stb_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      done_cnt0_q   <= '0;
      done_cnt1_q   <= '0;
      timer_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples its _d at the same edge.
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      req_ack_q     <= req_ack_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      eng_dat_stb_q <= eng_dat_stb_d;
      eng_datain_q  <= eng_datain_d;
      eng_o_stb_q   <= eng_o_stb_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      done_cnt0_q   <= done_cnt0_d;
      done_cnt1_q   <= done_cnt1_d;
      timer_q       <= timer_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign eng_dat_stb = eng_dat_stb_q;
  assign eng_datain  = eng_datain_q;
  assign eng_o_stb   = eng_o_stb_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;
  assign grant       = grant_q;
  assign done_cnt0   = done_cnt0_q;
  assign done_cnt1   = done_cnt1_q;

endmodule

// File: doc/aes_engine_arbiter.md
Name: aes_engine_arbiter

Overview:
- Shares one AES core (encryptor or decryptor, standard datain/dat_stb/o_valid/dataout/o_stb/ready handshake) between two requesters.
- Channel 0 is the Diffie-Hellman key-exchange path; channel 1 is the user data path.
- Sequences one block at a time: issue, wait for result, deliver to the owning requester, then release the core with o_stb.
- Includes round-robin/priority arbitration, key-valid gating, a response timeout and per-channel completion counters.

Parameters:
- TIMEOUT, 1024: cycles allowed in WAIT_RESULT before abort; must be >= 2.
- CH0_PRIORITY, 0: 1 = channel 0 always wins contention; 0 = round-robin.
- CNT_W, 16: width of each per-channel completion counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  current key loaded in core; no grant while low
- req_valid  in  2  per-channel request; bit n = channel n
- req_data0  in  128  channel 0 block
- req_data1  in  128  channel 1 block
- req_ack  out  2  one-cycle pulse: block of channel n accepted by core
- resp_valid  out  2  result available for channel n; held until taken
- resp_data  out  128  result block; valid while any resp_valid bit is set
- resp_ready  in  2  channel n consumes result
- eng_ready  in  1  core ready
- eng_dat_stb  out  1  core data strobe
- eng_datain  out  128  core data input
- eng_o_valid  in  1  core result valid
- eng_dataout  in  128  core result
- eng_o_stb  out  1  core output-release pulse
- busy  out  1  state != IDLE
- grant  out  1  channel owning the current transaction
- timeout_err  out  1  one-cycle pulse on abort
- done_cnt0  out  CNT_W  completed channel 0 transactions
- done_cnt1  out  CNT_W  completed channel 1 transactions

Behaviour:
- All outputs are registered. Reset (async) forces: state IDLE; req_ack, resp_valid, eng_dat_stb, eng_o_stb, timeout_err, busy = 0; resp_data, eng_datain, done_cnt0, done_cnt1 = 0; grant = 0; last_grant = 1, so channel 1 is treated as last served and channel 0 wins the first contention.
- IDLE:
  - Exit when eng_ready & key_valid & |req_valid.
  - Single requester: grant that channel.
  - Both requesting: if CH0_PRIORITY, grant channel 0; otherwise grant ~last_grant.
  - Latch the granted data into eng_datain, set grant, go to ISSUE.
- ISSUE, exactly 1 cycle: eng_dat_stb = 1 and req_ack[grant] = 1 in the same cycle. Clear the timer, go to WAIT_RESULT.
- WAIT_RESULT:
  - The timer increments each cycle.
  - If eng_o_valid: capture eng_dataout into resp_data, set resp_valid[grant] on the next cycle, go to DELIVER.
  - Else if the timer reaches TIMEOUT-1: pulse timeout_err and go to RELEASE with no delivery; the counter is not incremented.
  - If eng_o_valid and timeout coincide, eng_o_valid wins.
- DELIVER:
  - Hold resp_valid[grant] and resp_data stable.
  - resp_ready of the non-granted channel is ignored.
  - When resp_ready[grant] is 1: clear resp_valid, increment done_cnt[grant] (wraps modulo 2^CNT_W), go to RELEASE.
- RELEASE, exactly 1 cycle: eng_o_stb = 1; last_grant <= grant; go to IDLE. At the earliest, a new grant is evaluated in IDLE the following cycle.
- Transaction latency:
  - Minimum from request seen in IDLE to resp_valid: 3 cycles plus core latency.
  - Back-to-back: 2 idle cycles after resp_ready (RELEASE, IDLE).
- key_valid dropping after grant does not abort an in-flight transaction. It only blocks new grants.
- req_valid dropping before req_ack has no effect once granted: the data was already latched.
- A requester must hold req_valid and req_data until req_ack.
- Mid-operation reset returns everything to reset values immediately. No eng_o_stb is issued; the core is expected to share the same reset.
- At most one of req_ack, resp_valid bits is set at any time. eng_dat_stb and eng_o_stb are never high together.

Test Plan:
- Single request: key_valid=1, eng_ready=1, req_valid=01, req_data0=0x00112233445566778899AABBCCDDEEFF; core returns 0x69C4E0D86A7B0430D8CDB78070B4C55A after 10 cycles; resp_ready=01 -> one req_ack[0] pulse, eng_datain equals data0, resp_valid=01 with that value, eng_o_stb one pulse, done_cnt0=1.
- Contention, round-robin (CH0_PRIORITY=0): both channels request continuously for 4 transactions, immediate resp_ready -> grant order 0,1,0,1; done_cnt0=done_cnt1=2.
- Contention with CH0_PRIORITY=1: same stimulus -> four channel 0 grants; channel 1 gets no req_ack.
- Gating: key_valid=0, req_valid=11 for 20 cycles -> no eng_dat_stb, busy=0. Raise key_valid -> grant to channel 0 next cycle.
- Timeout: TIMEOUT=8, core never asserts eng_o_valid -> timeout_err pulse 8 cycles after ISSUE, then eng_o_stb pulse, no resp_valid, counters unchanged, back to IDLE.
- Backpressure and reset: hold resp_ready=0 for 50 cycles -> resp_valid and resp_data stable, no eng_o_stb. Assert reset mid-DELIVER -> all outputs 0 asynchronously, done counters 0.
